// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_sub_pkg;

    localparam int unsigned DefaultWidth = 8;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } state_e;

endpackage

// File: rtl/fs_cell.sv
// Combinational full-subtractor cell: diff = x - y - bi, with borrow-out.
module fs_cell (
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic diff,
    output logic bo
);

    always_comb begin
        diff = x ^ y ^ bi;
        bo   = (~x & y) | (~(x ^ y) & bi);
    end

endmodule

// File: rtl/serial_sub.sv
// Bit-serial N-bit subtractor: one fs_cell plus a borrow flop, LSB first,
// with a start/busy/done handshake and registered result outputs.
module serial_sub
    import serial_sub_pkg::*;
#(
    parameter int unsigned N = DefaultWidth
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         bin,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] d,
    output logic         bout,
    output logic         ovf
);

    localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(N - 1);

    state_e          state_q, state_d;
    logic [N-1:0]    a_sr_q, b_sr_q, d_sr_q;
    logic [CntW-1:0] cnt_q;
    logic            brw_q;
    logic            a_msb_q, b_msb_q;
    logic [N-1:0]    d_q;
    logic            bout_q, ovf_q;

    logic            cell_diff, cell_bo;
    logic            last_bit;
    logic [N-1:0]    d_sr_next;

    fs_cell u_cell (
        .x    (a_sr_q[0]),
        .y    (b_sr_q[0]),
        .bi   (brw_q),
        .diff (cell_diff),
        .bo   (cell_bo)
    );

    always_comb begin
        last_bit  = (state_q == StShift) && (cnt_q == CntLast);
        d_sr_next = {cell_diff, d_sr_q[N-1:1]};
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StShift;
            StShift: if (cnt_q == CntLast) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            d_sr_q  <= '0;
            cnt_q   <= '0;
            brw_q   <= 1'b0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
        end else if (state_q == StIdle && start) begin
            a_sr_q  <= a;
            b_sr_q  <= b;
            brw_q   <= bin;
            cnt_q   <= '0;
            a_msb_q <= a[N-1];
            b_msb_q <= b[N-1];
        end else if (state_q == StShift) begin
            d_sr_q <= d_sr_next;
            a_sr_q <= a_sr_q >> 1;
            b_sr_q <= b_sr_q >> 1;
            brw_q  <= cell_bo;
            cnt_q  <= cnt_q + 1'b1;
        end
    end

    // Result registers load on the edge entering DONE; the final diff bit is
    // the new MSB, so overflow is judged from the cell output directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_q    <= '0;
            bout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (last_bit) begin
            d_q    <= d_sr_next;
            bout_q <= cell_bo;
            ovf_q  <= (a_msb_q ^ b_msb_q) & (cell_diff ^ a_msb_q);
        end
    end

    always_comb begin
        busy = (state_q != StIdle);
        done = (state_q == StDone);
        d    = d_q;
        bout = bout_q;
        ovf  = ovf_q;
    end

endmodule

// File: tb/tb_serial_sub.sv
// Directed self-checking bench for serial_sub (N = 8).
module tb_serial_sub;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] a, b;
    logic       bin;
    logic       busy, done;
    logic [7:0] d;
    logic       bout, ovf;

    int tests;
    int fails;

    serial_sub #(.N(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .d     (d),
        .bout  (bout),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Golden model: {ovf, bout, d}
    function automatic logic [9:0] sub_model(input logic [7:0] av, input logic [7:0] bv,
                                             input logic bi);
        logic [8:0] r;
        logic       o;
        r = {1'b0, av} - {1'b0, bv} - {8'd0, bi};
        o = (av[7] != bv[7]) && (r[7] != av[7]);
        return {o, r[8], r[7:0]};
    endfunction

    // Runs one operation; operands are scrambled right after the accepting edge.
    task automatic do_op(input logic [7:0] av, input logic [7:0] bv, input logic bi,
                         output int lat, output int busy_cycles, output int done_pulses,
                         output logic [7:0] dv, output logic bo, output logic ov);
        lat = -1; busy_cycles = 0; done_pulses = 0; dv = '0; bo = 1'b0; ov = 1'b0;
        @(negedge clk);
        a = av; b = bv; bin = bi; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; a = ~av; b = ~bv; bin = ~bi;
        if (busy) busy_cycles++;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (busy) busy_cycles++;
            if (done) begin
                done_pulses++;
                if (lat < 0) begin
                    lat = k; dv = d; bo = bout; ov = ovf;
                end
            end
            if (!busy) break;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1; start = 1'b0; a = 8'h00; b = 8'h00; bin = 1'b0;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if ({busy, done, d, bout, ovf} !== 12'h000) begin
            $display("FAIL reset_state: got busy=%b done=%b d=%h bout=%b ovf=%b, want all 0",
                     busy, done, d, bout, ovf);
            fails++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        tests++;
        if (busy !== 1'b0) begin
            $display("FAIL idle_no_start: busy=%b want 0", busy);
            fails++;
        end
    endtask

    task automatic test_basic();
        int lat, bc, dp;
        logic [7:0] dv;
        logic bo, ov;
        do_op(8'h35, 8'h12, 1'b0, lat, bc, dp, dv, bo, ov);
        tests++;
        if (lat !== 8) begin
            $display("FAIL basic_latency: got %0d want 8", lat); fails++;
        end
        tests++;
        if (bc !== 9) begin
            $display("FAIL basic_busy_cycles: got %0d want 9", bc); fails++;
        end
        tests++;
        if (dp !== 1) begin
            $display("FAIL basic_done_pulses: got %0d want 1", dp); fails++;
        end
        tests++;
        if ({ov, bo, dv} !== {1'b0, 1'b0, 8'h23}) begin
            $display("FAIL basic_result: got d=%h bout=%b ovf=%b want d=23 bout=0 ovf=0",
                     dv, bo, ov);
            fails++;
        end
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if ({ovf, bout, d} !== {1'b0, 1'b0, 8'h23} || busy !== 1'b0) begin
            $display("FAIL basic_hold: got d=%h bout=%b ovf=%b busy=%b want d=23 0 0 0",
                     d, bout, ovf, busy);
            fails++;
        end
    endtask

    task automatic test_borrow();
        int lat, bc, dp;
        logic [7:0] dv;
        logic bo, ov;
        do_op(8'h12, 8'h35, 1'b0, lat, bc, dp, dv, bo, ov);
        tests++;
        if ({ov, bo, dv} !== {1'b0, 1'b1, 8'hDD}) begin
            $display("FAIL neg_result: got d=%h bout=%b ovf=%b want d=dd bout=1 ovf=0",
                     dv, bo, ov);
            fails++;
        end
        do_op(8'h10, 8'h0F, 1'b1, lat, bc, dp, dv, bo, ov);
        tests++;
        if ({bo, dv} !== {1'b0, 8'h00} || lat !== 8) begin
            $display("FAIL bin_zero: got d=%h bout=%b lat=%0d want d=00 bout=0 lat=8",
                     dv, bo, lat);
            fails++;
        end
        do_op(8'h00, 8'h00, 1'b1, lat, bc, dp, dv, bo, ov);
        tests++;
        if ({ov, bo, dv} !== {1'b0, 1'b1, 8'hFF}) begin
            $display("FAIL bin_wrap: got d=%h bout=%b ovf=%b want d=ff bout=1 ovf=0",
                     dv, bo, ov);
            fails++;
        end
    endtask

    task automatic test_ovf();
        int lat, bc, dp;
        logic [7:0] dv;
        logic bo, ov;
        do_op(8'h80, 8'h01, 1'b0, lat, bc, dp, dv, bo, ov);
        tests++;
        if ({ov, bo, dv} !== {1'b1, 1'b0, 8'h7F}) begin
            $display("FAIL ovf_neg: got d=%h bout=%b ovf=%b want d=7f bout=0 ovf=1",
                     dv, bo, ov);
            fails++;
        end
        do_op(8'h7F, 8'hFF, 1'b0, lat, bc, dp, dv, bo, ov);
        tests++;
        if ({ov, bo, dv} !== {1'b1, 1'b1, 8'h80}) begin
            $display("FAIL ovf_pos: got d=%h bout=%b ovf=%b want d=80 bout=1 ovf=1",
                     dv, bo, ov);
            fails++;
        end
    endtask

    // start held high with fresh operands every cycle; edge index 0 accepts first op.
    task automatic test_back_to_back();
        int         done_k[3];
        logic [9:0] res[3];
        logic [9:0] exp_res[3];
        int         nd, consec;
        logic       prev_done;
        nd = 0; consec = 0; prev_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            done_k[i] = -1; res[i] = '0;
        end
        exp_res[0] = 10'({1'b0, 1'b0, 8'h23});
        exp_res[1] = sub_model(8'h52, 8'h66, 1'b1);
        exp_res[2] = sub_model(8'hC4, 8'hD4, 1'b1);
        @(negedge clk);
        a = 8'h35; b = 8'h12; bin = 1'b0; start = 1'b1;
        for (int k = 0; k <= 32; k++) begin
            @(posedge clk);
            #1;
            if (done && prev_done) consec++;
            prev_done = done;
            if (done) begin
                if (nd < 3) begin
                    done_k[nd] = k; res[nd] = {ovf, bout, d};
                end
                nd++;
            end
            @(negedge clk);
            a = 8'(k * 37 + 5); b = 8'(k * 11 + 3); bin = k[0]; start = (k < 20);
        end
        start = 1'b0;
        tests++;
        if (nd !== 3 || consec !== 0) begin
            $display("FAIL b2b_done_count: got %0d pulses, %0d consecutive; want 3, 0",
                     nd, consec);
            fails++;
        end
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (done_k[i] !== 8 + 10 * i) begin
                $display("FAIL b2b_timing_%0d: done at edge %0d want %0d",
                         i, done_k[i], 8 + 10 * i);
                fails++;
            end
            tests++;
            if (res[i] !== exp_res[i]) begin
                $display("FAIL b2b_result_%0d: got {ovf,bout,d}=%h want %h",
                         i, res[i], exp_res[i]);
                fails++;
            end
        end
    endtask

    task automatic test_mid_reset();
        int lat, bc, dp, seen;
        logic [7:0] dv;
        logic bo, ov;
        logic [9:0] exp_r;
        @(negedge clk);
        a = 8'h35; b = 8'h12; bin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests++;
        if ({busy, done, d, bout, ovf} !== 12'h000) begin
            $display("FAIL midreset_outputs: got busy=%b done=%b d=%h bout=%b ovf=%b want 0",
                     busy, done, d, bout, ovf);
            fails++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk);
            #1;
            if (done || busy) seen++;
        end
        tests++;
        if (seen !== 0) begin
            $display("FAIL midreset_no_done: %0d busy/done cycles after abort, want 0", seen);
            fails++;
        end
        exp_r = sub_model(8'hA5, 8'h3C, 1'b0);
        do_op(8'hA5, 8'h3C, 1'b0, lat, bc, dp, dv, bo, ov);
        tests++;
        if ({ov, bo, dv} !== exp_r || lat !== 8) begin
            $display("FAIL midreset_recover: got {ovf,bout,d}=%h lat=%0d want %h lat=8",
                     {ov, bo, dv}, lat, exp_r);
            fails++;
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_basic();
        test_borrow();
        test_ovf();
        test_mid_reset();
        test_back_to_back();
        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
